// File: rtl/reg_file_wb_if.sv
// Bus bundle for the write-back register file: write-back, read ports, issue and scoreboard status.
// The master side drives writes, reads and issues; the slave side is the register file.
interface reg_file_wb_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    localparam int NREG = 1 << ADDR_W;

    logic              RegWrite;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic              Use1;
    logic              Use2;
    logic              IssueValid;
    logic [ADDR_W-1:0] IssueDst;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic              Stall;
    logic [NREG-1:0]   BusyVec;

    modport master (
        output RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
               Use1, Use2, IssueValid, IssueDst,
        input  ReadData1, ReadData2, Stall, BusyVec
    );

    modport slave (
        input  RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
               Use1, Use2, IssueValid, IssueDst,
        output ReadData1, ReadData2, Stall, BusyVec
    );
endinterface

// File: rtl/reg_file_wb.sv
// Write-back register file with two combinational read ports and a per-register busy scoreboard.
// Optional REGFILE_BYPASS_EN forwards same-cycle write-back data and busy clears into reads and Stall.
module reg_file_wb #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input logic          clk,
    input logic          rst,
    reg_file_wb_if.slave bus
);
    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   issue_hit;
    logic [NREG-1:0]   clr_hit;
    logic [NREG-1:0]   set_vec;
    logic [NREG-1:0]   busy_eff;
    logic              stall;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    // Index 0 is skipped so R0 can never be marked busy or cleared.
    always_comb begin
        issue_hit = '0;
        clr_hit   = '0;
        for (int i = 1; i < NREG; i++) begin
            issue_hit[i] = bus.IssueValid && (bus.IssueDst == ADDR_W'(i));
            clr_hit[i]   = bus.RegWrite   && (bus.WriteReg == ADDR_W'(i));
        end
    end

`ifdef REGFILE_BYPASS_EN
    // The raw issue request (not gated by Stall) keeps the clear-forwarding term free of a loop.
    assign busy_eff = busy & ~(clr_hit & ~issue_hit);
`else
    assign busy_eff = busy;
`endif

    assign stall   = (bus.Use1 && busy_eff[bus.ReadReg1]) ||
                     (bus.Use2 && busy_eff[bus.ReadReg2]);
    assign set_vec = issue_hit & {NREG{~stall}};

    // Set is OR-ed after clear so a same-cycle issue to the written reg keeps it busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr_hit) | set_vec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.RegWrite && (bus.WriteReg != '0)) begin
            regs[bus.WriteReg] <= bus.WriteData;
        end
    end

    always_comb begin
        rd1 = (bus.ReadReg1 == '0) ? '0 : regs[bus.ReadReg1];
        rd2 = (bus.ReadReg2 == '0) ? '0 : regs[bus.ReadReg2];
`ifdef REGFILE_BYPASS_EN
        if (bus.RegWrite && (bus.WriteReg != '0) && (bus.WriteReg == bus.ReadReg1)) begin
            rd1 = bus.WriteData;
        end
        if (bus.RegWrite && (bus.WriteReg != '0) && (bus.WriteReg == bus.ReadReg2)) begin
            rd2 = bus.WriteData;
        end
`endif
    end

    assign bus.ReadData1 = rd1;
    assign bus.ReadData2 = rd2;
    assign bus.Stall     = stall;
    assign bus.BusyVec   = busy;
endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: directed vector table, multi-cycle corner sequences,
// and randomized traffic against an array-based reference model.
module tb_reg_file_wb;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int NREG   = 8;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    reg_file_wb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    reg_file_wb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [DATA_W-1:0] m_r [NREG];
    bit   [NREG-1:0]   m_busy;

    typedef struct {
        logic              we;
        logic [2:0]        wr;
        logic [15:0]       wd;
        logic [2:0]        r1;
        logic [2:0]        r2;
        logic              u1;
        logic              u2;
        logic              iv;
        logic [2:0]        id;
        logic [15:0]       e_rd1;
        logic [15:0]       e_rd2;
        logic              e_stall;
        logic [7:0]        e_busy;
    } vec_t;

    vec_t tbl [11];

    function automatic vec_t mk(logic we, logic [2:0] wr, logic [15:0] wd,
                                logic [2:0] r1, logic [2:0] r2, logic u1, logic u2,
                                logic iv, logic [2:0] id,
                                logic [15:0] e1, logic [15:0] e2, logic es, logic [7:0] eb);
        vec_t v;
        v.we = we; v.wr = wr; v.wd = wd; v.r1 = r1; v.r2 = r2;
        v.u1 = u1; v.u2 = u2; v.iv = iv; v.id = id;
        v.e_rd1 = e1; v.e_rd2 = e2; v.e_stall = es; v.e_busy = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] wr, input logic [15:0] wd,
                         input logic [2:0] r1, input logic [2:0] r2, input logic u1,
                         input logic u2, input logic iv, input logic [2:0] id);
        bus.RegWrite = we; bus.WriteReg = wr; bus.WriteData = wd;
        bus.ReadReg1 = r1; bus.ReadReg2 = r2; bus.Use1 = u1; bus.Use2 = u2;
        bus.IssueValid = iv; bus.IssueDst = id;
    endtask

    function automatic logic [15:0] exp_rd(logic [2:0] r);
`ifdef REGFILE_BYPASS_EN
        if (bus.RegWrite && bus.WriteReg == r && r != 0) return bus.WriteData;
`endif
        return (r == 0) ? 16'h0 : m_r[r];
    endfunction

    function automatic bit eff_busy(logic [2:0] r);
        bit b;
        b = m_busy[r];
`ifdef REGFILE_BYPASS_EN
        if (bus.RegWrite && bus.WriteReg == r && !(bus.IssueValid && bus.IssueDst == r)) b = 1'b0;
`endif
        return b;
    endfunction

    function automatic logic exp_stall();
        return (bus.Use1 && eff_busy(bus.ReadReg1)) || (bus.Use2 && eff_busy(bus.ReadReg2));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_r[i] = '0;
        m_busy = '0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_update();
        logic s;
        s = exp_stall();
        if (bus.RegWrite && bus.WriteReg != 0) m_r[bus.WriteReg] = bus.WriteData;
        if (bus.RegWrite) m_busy[bus.WriteReg] = 1'b0;
        if (bus.IssueValid && !s && bus.IssueDst != 0) m_busy[bus.IssueDst] = 1'b1;
        m_busy[0] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_update();
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".rd1"},   32'(bus.ReadData1), 32'(exp_rd(bus.ReadReg1)));
        chk({tag, ".rd2"},   32'(bus.ReadData2), 32'(exp_rd(bus.ReadReg2)));
        chk({tag, ".stall"}, 32'(bus.Stall),     32'(exp_stall()));
        chk({tag, ".busy"},  32'(bus.BusyVec),   32'(m_busy));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model_reset();

        tbl[0]  = mk(0, 0, 16'h0000, 3, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 8'h00);
        tbl[1]  = mk(1, 5, 16'hBEEF, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 8'h00);
        tbl[2]  = mk(1, 0, 16'hFFFF, 0, 5, 0, 0, 0, 0, 16'h0000, 16'hBEEF, 0, 8'h00);
        tbl[3]  = mk(0, 0, 16'h0000, 0, 5, 0, 0, 0, 0, 16'h0000, 16'hBEEF, 0, 8'h00);
        tbl[4]  = mk(0, 0, 16'h0000, 0, 0, 0, 0, 1, 4, 16'h0000, 16'h0000, 0, 8'h00);
        tbl[5]  = mk(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 8'h10);
        tbl[6]  = mk(1, 4, 16'h4444, 0, 0, 0, 0, 1, 4, 16'h0000, 16'h0000, 0, 8'h10);
        tbl[7]  = mk(0, 0, 16'h0000, 4, 0, 0, 0, 0, 0, 16'h4444, 16'h0000, 0, 8'h10);
        tbl[8]  = mk(0, 0, 16'h0000, 4, 0, 1, 0, 1, 6, 16'h4444, 16'h0000, 1, 8'h10);
        tbl[9]  = mk(0, 0, 16'h0000, 4, 0, 1, 0, 0, 0, 16'h4444, 16'h0000, 1, 8'h10);
        tbl[10] = mk(0, 0, 16'h0000, 4, 5, 0, 0, 0, 0, 16'h4444, 16'hBEEF, 0, 8'h10);

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 11; k++) begin
            drive(tbl[k].we, tbl[k].wr, tbl[k].wd, tbl[k].r1, tbl[k].r2,
                  tbl[k].u1, tbl[k].u2, tbl[k].iv, tbl[k].id);
            #1;
            chk($sformatf("tbl%0d.rd1", k),   32'(bus.ReadData1), 32'(tbl[k].e_rd1));
            chk($sformatf("tbl%0d.rd2", k),   32'(bus.ReadData2), 32'(tbl[k].e_rd2));
            chk($sformatf("tbl%0d.stall", k), 32'(bus.Stall),     32'(tbl[k].e_stall));
            chk($sformatf("tbl%0d.busy", k),  32'(bus.BusyVec),   32'(tbl[k].e_busy));
            tick();
        end

        // Scoreboard release after write-back to R2
        drive(0, 0, 0, 0, 0, 0, 0, 1, 2);
        tick();
        drive(0, 0, 0, 2, 0, 1, 0, 0, 0);
        #1;
        chk("sb.stall_busy", 32'(bus.Stall), 32'd1);
        tick();
        drive(1, 2, 16'h0042, 2, 0, 1, 0, 0, 0);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("sb.stall_wb", 32'(bus.Stall), 32'd0);
        chk("sb.rd1_wb", 32'(bus.ReadData1), 32'h0042);
`else
        chk("sb.stall_wb", 32'(bus.Stall), 32'd1);
`endif
        tick();
        drive(0, 0, 0, 2, 0, 1, 0, 0, 0);
        #1;
        chk("sb.stall_after", 32'(bus.Stall), 32'd0);
        chk("sb.rd1_after", 32'(bus.ReadData1), 32'h0042);
        chk("sb.busy2", 32'(bus.BusyVec[2]), 32'd0);
        tick();

        // Same-cycle write-back and read of R7
        drive(1, 7, 16'h1111, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 7, 16'h0A0A, 7, 7, 0, 0, 0, 0);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp.rd1", 32'(bus.ReadData1), 32'h0A0A);
        chk("byp.rd2", 32'(bus.ReadData2), 32'h0A0A);
`else
        chk("byp.rd1", 32'(bus.ReadData1), 32'h1111);
        chk("byp.rd2", 32'(bus.ReadData2), 32'h1111);
`endif
        tick();
        drive(0, 0, 0, 7, 7, 0, 0, 0, 0);
        #1;
        chk("byp.rd1_next", 32'(bus.ReadData1), 32'h0A0A);
        chk("byp.rd2_next", 32'(bus.ReadData2), 32'h0A0A);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom),
                  3'($urandom), 3'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 3'($urandom));
            #1;
            check_model($sformatf("rnd%0d", n));
            tick();
        end

        // Asynchronous reset mid-cycle with R3 written and busy
        drive(1, 3, 16'h1234, 0, 0, 0, 0, 1, 3);
        tick();
        drive(0, 0, 0, 3, 0, 0, 0, 0, 0);
        #1;
        chk("rst.pre_rd1", 32'(bus.ReadData1), 32'h1234);
        chk("rst.pre_busy3", 32'(bus.BusyVec[3]), 32'd1);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst.busy", 32'(bus.BusyVec), 32'd0);
        chk("rst.rd1", 32'(bus.ReadData1), 32'd0);
        chk("rst.stall", 32'(bus.Stall), 32'd0);
        drive(1, 3, 16'h5555, 3, 3, 0, 0, 1, 3);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 3, 0, 0, 0, 0, 0);
        #1;
        chk("rst.discard_rd1", 32'(bus.ReadData1), 32'd0);
        chk("rst.discard_busy", 32'(bus.BusyVec), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
